// File: rtl/spi_target_regport_if.sv
// Register-port bundle for spi_target_regport: SPI pins plus the local write/read port.
// The slave modport is the SPI target side; the master modport is the SPI master and fabric side.
interface spi_target_regport_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              spi_SCLK;
  logic              spi_SS_n;
  logic              spi_MOSI;
  logic              spi_MISO;
  logic              spi_MISO_oe;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_strobe;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              busy;

  modport slave (
    input  spi_SCLK, spi_SS_n, spi_MOSI, rd_data,
    output spi_MISO, spi_MISO_oe, wr_valid, wr_addr, wr_data, rd_strobe, rd_addr, busy
  );

  modport master (
    output spi_SCLK, spi_SS_n, spi_MOSI, rd_data,
    input  spi_MISO, spi_MISO_oe, wr_valid, wr_addr, wr_data, rd_strobe, rd_addr, busy
  );
endinterface

// File: rtl/spi_target_regport.sv
// Mode-0 SPI target decoding command/data bytes into a byte-wide register port, oversampled
// in clk_clk. Optional irq output (write-frame completion pulse) built when SPI_TARGET_IRQ_EN.
module spi_target_regport #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  spi_target_regport_if.slave  bus
`ifdef SPI_TARGET_IRQ_EN
  ,
  output logic                 irq
`endif
);

  typedef enum logic [1:0] {StIdle, StCmd, StWData, StRData} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES:0]   sync_vld_q, sync_vld_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   armed_q, armed_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   miso_q, miso_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   rd_strobe_q, rd_strobe_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;

  logic       sclk_s, ss_s, mosi_s;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [7:0] byte_in;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~ss_s & sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~ss_s & ~sclk_s & sclk_prev_q;
  // armed_q blocks a frame start from an SS_n that was already low when reset released.
  assign ss_fall   = armed_q & ss_prev_q & ~ss_s;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign byte_in   = {rx_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.spi_SS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_MOSI};
    sync_vld_d  = {sync_vld_q[SYNC_STAGES-1:0], 1'b1};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    armed_d     = armed_q | (sync_vld_q[SYNC_STAGES] & ss_s);
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    rd_addr_d   = rd_addr_q;

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d   = StCmd;
          bit_cnt_d = 3'd0;
          rx_d      = 7'd0;
          miso_d    = 1'b0;
        end
      end
      StCmd: begin
        if (sclk_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d = byte_in[ADDR_W-1:0];
            if (byte_in[7]) begin
              state_d = StWData;
            end else begin
              state_d     = StRData;
              rd_strobe_d = 1'b1;
              rd_addr_d   = byte_in[ADDR_W-1:0];
            end
          end
        end
      end
      StWData: begin
        if (sclk_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = byte_in;
            addr_d     = addr_q + ADDR_W'(1);
          end
        end
      end
      StRData: begin
        if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d      = addr_q + ADDR_W'(1);
            rd_strobe_d = 1'b1;
            rd_addr_d   = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Fabric guarantees rd_data on the edge that ends the rd_strobe cycle.
    if (rd_strobe_q) tx_d = bus.rd_data;

    if (state_q != StIdle && ss_rise) begin
      state_d = StIdle;
      miso_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sync_vld_q  <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      rd_strobe_q <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sync_vld_q  <= sync_vld_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign bus.spi_MISO    = miso_q;
  assign bus.spi_MISO_oe = (state_q != StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_strobe   = rd_strobe_q;
  assign bus.rd_addr     = rd_addr_q;

`ifdef SPI_TARGET_IRQ_EN
  logic wrote_q, wrote_d;
  logic irq_q, irq_d;

  always_comb begin
    wrote_d = wrote_q;
    if (state_q == StIdle && ss_fall) wrote_d = 1'b0;
    if (wr_valid_d) wrote_d = 1'b1;
    irq_d = (state_q != StIdle) && ss_rise && wrote_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wrote_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      wrote_q <= wrote_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_target_regport.sv
// Directed bench for spi_target_regport: write/read bursts, address wrap, abort, reset mid-frame,
// plus irq checks when built with SPI_TARGET_IRQ_EN.
module tb_spi_target_regport;
  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   irq_cnt = 0;

  logic [14:0] wr_log[$];
  logic [6:0]  rd_log[$];
  logic [7:0]  rx_a, rx_b;

  spi_target_regport_if #(.ADDR_W(7)) bus ();

`ifdef SPI_TARGET_IRQ_EN
  logic irq;
`endif

  spi_target_regport #(.ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus)
`ifdef SPI_TARGET_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  // Local fabric model: read data is the address XOR 0xA5.
  assign bus.rd_data = {1'b0, bus.rd_addr} ^ 8'hA5;

  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (bus.wr_valid) wr_log.push_back({bus.wr_addr, bus.wr_data});
      if (bus.rd_strobe) rd_log.push_back(bus.rd_addr);
`ifdef SPI_TARGET_IRQ_EN
      if (irq) irq_cnt++;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.spi_MOSI = v[7-i];
      #50 bus.spi_SCLK = 1'b1;
      r[7-i] = bus.spi_MISO;
      #50 bus.spi_SCLK = 1'b0;
    end
  endtask

  task automatic ss_low();
    wr_log.delete();
    rd_log.delete();
    irq_cnt = 0;
    bus.spi_SS_n = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #50 bus.spi_SS_n = 1'b1;
    #200;
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, bus.busy, bus.spi_MISO_oe, bus.spi_MISO, bus.wr_valid, bus.rd_strobe,
            bus.wr_addr, bus.wr_data, bus.rd_addr} >> 0;
  endfunction

  initial begin
    bus.spi_SCLK = 1'b0;
    bus.spi_SS_n = 1'b1;
    bus.spi_MOSI = 1'b0;
    #53;
    check("reset_outputs", outs(), 32'd0);
    reset_reset_n = 1'b1;
    #100;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Write burst
    ss_low();
    check("wr_busy_oe", {30'd0, bus.busy, bus.spi_MISO_oe}, 32'd3);
    spi_bits(8'h85, 8, rx_a);
    check("wr_miso_cmd", {24'd0, rx_a}, 32'h00);
    spi_bits(8'h11, 8, rx_a);
    spi_bits(8'h22, 8, rx_b);
    check("wr_miso_data", {16'd0, rx_a, rx_b}, 32'h0000);
    ss_high();
    check("wr_count", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      check("wr0", {17'd0, wr_log[0]}, {17'd0, 7'h05, 8'h11});
      check("wr1", {17'd0, wr_log[1]}, {17'd0, 7'h06, 8'h22});
    end
    check("wr_end_busy", {30'd0, bus.busy, bus.spi_MISO_oe}, 32'd0);
`ifdef SPI_TARGET_IRQ_EN
    check("irq_write", irq_cnt, 1);
`endif

    // Read burst
    ss_low();
    spi_bits(8'h10, 8, rx_a);
    check("rd_miso_cmd", {24'd0, rx_a}, 32'h00);
    spi_bits(8'h00, 8, rx_a);
    spi_bits(8'h00, 8, rx_b);
    check("rd_bytes", {16'd0, rx_a, rx_b}, 32'hB5B4);
    ss_high();
    check("rd_count", rd_log.size(), 3);
    if (rd_log.size() >= 3)
      check("rd_addrs", {11'd0, rd_log[0], rd_log[1], rd_log[2]}, {11'd0, 7'h10, 7'h11, 7'h12});
    check("rd_no_wr", wr_log.size(), 0);
    check("rd_end_miso", {30'd0, bus.spi_MISO, bus.spi_MISO_oe}, 32'd0);
`ifdef SPI_TARGET_IRQ_EN
    check("irq_read", irq_cnt, 0);
`endif

    // Address wrap
    ss_low();
    spi_bits(8'hFF, 8, rx_a);
    spi_bits(8'hAA, 8, rx_a);
    spi_bits(8'hBB, 8, rx_a);
    ss_high();
    check("wrap_count", wr_log.size(), 2);
    if (wr_log.size() >= 2)
      check("wrap_pair", {2'd0, wr_log[0], wr_log[1]}, {2'd0, 7'h7F, 8'hAA, 7'h00, 8'hBB});

    // Abort after 5 data bits, then a good frame
    ss_low();
    spi_bits(8'h83, 8, rx_a);
    spi_bits(8'hF0, 5, rx_a);
    ss_high();
    check("abort_no_wr", wr_log.size(), 0);
`ifdef SPI_TARGET_IRQ_EN
    check("irq_abort", irq_cnt, 0);
`endif
    ss_low();
    spi_bits(8'h83, 8, rx_a);
    spi_bits(8'h44, 8, rx_a);
    ss_high();
    check("after_abort_count", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("after_abort_wr", {17'd0, wr_log[0]}, {17'd0, 7'h03, 8'h44});

    // Empty frame and SCLK with SS_n high
    ss_low();
    ss_high();
    spi_bits(8'h81, 8, rx_a);
    #200;
    check("empty_strobes", wr_log.size() + rd_log.size(), 0);
    check("sclk_ss_high_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-frame, SS_n held low through release
    ss_low();
    spi_bits(8'h81, 8, rx_a);
    spi_bits(8'hC0, 4, rx_a);
    reset_reset_n = 1'b0;
    #1;
    check("midreset_outputs", outs(), 32'd0);
    #40 reset_reset_n = 1'b1;
    #100;
    spi_bits(8'h81, 8, rx_a);
    #200;
    check("held_ss_no_frame", {31'd0, bus.busy}, 32'd0);
    check("held_ss_no_wr", wr_log.size(), 0);
    ss_high();
    ss_low();
    spi_bits(8'h81, 8, rx_a);
    spi_bits(8'h5A, 8, rx_a);
    ss_high();
    check("restart_count", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("restart_wr", {17'd0, wr_log[0]}, {17'd0, 7'h01, 8'h5A});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_target_regport.md
Name: spi_target_regport

Overview:
- SPI target (responder) that sits at the far end of the SoC's SPI master link, e.g. on a companion FPGA or a loopback test fixture.
- Decodes mode-0 (CPOL=0, CPHA=0), MSB-first frames into a byte-wide register-port protocol for local fabric logic.
- Writes go out as single-cycle strobes. Reads are fetched from local logic through an address/data port and shifted out on MISO.
- All SPI pins are oversampled in the system clock domain; no logic is clocked by SCLK.

Parameters:
ADDR_W, 7, register address width; the command byte carries a 1-bit R/W flag plus ADDR_W address bits (ADDR_W must be 7)
SYNC_STAGES, 2, synchronizer depth applied to SCLK, SS_n and MOSI (legal values 2..3)

Ports:
clk_clk  input  1  system clock; SCLK must be <= clk_clk/8
reset_reset_n  input  1  asynchronous active-low reset
spi_SCLK  input  1  SPI clock from master
spi_SS_n  input  1  active-low target select
spi_MOSI  input  1  master-out data
spi_MISO  output  1  target-out data
spi_MISO_oe  output  1  MISO output enable; 1 while selected
wr_valid  output  1  one-cycle write strobe
wr_addr  output  ADDR_W  write address, valid with wr_valid
wr_data  output  8  write data, valid with wr_valid
rd_strobe  output  1  one-cycle read request
rd_addr  output  ADDR_W  read address, held from rd_strobe until the next rd_strobe
rd_data  input  8  read data; must be valid on the clk_clk edge after rd_strobe
busy  output  1  high while a frame is in progress

Behaviour:
- Reset: all outputs 0; FSM in IDLE; shift registers, bit counter and address counter cleared. Synchronizer flops reset to idle levels: SCLK=0, SS_n=1, MOSI=0.
- Edge detection: rise/fall pulses are derived from the synchronized SCLK. All edges are ignored while synchronized SS_n=1.
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD on synchronized SS_n falling edge:
  - bit counter=0, busy=1, spi_MISO_oe=1, spi_MISO=0.
- CMD: sample MOSI on each SCLK rise into rx shift; bit counter counts 0..7.
- On the 8th rise in CMD:
  - cmd[7]=1 -> write: latch addr=cmd[6:0], go to WDATA.
  - cmd[7]=0 -> read: latch addr, assert rd_strobe with rd_addr=addr, go to RDATA.
- WDATA, on each completed byte (8th rise):
  - next cycle: wr_valid=1 with wr_addr=addr and wr_data=byte.
  - then addr <= addr+1 mod 2^ADDR_W (0x7F wraps to 0x00).
- RDATA timing:
  - the cycle after rd_strobe, load rd_data into the tx shift register.
  - on the next SCLK fall, drive tx[7] onto spi_MISO.
  - each later fall shifts left and drives the next bit.
- RDATA, after the 8th rise of each data byte:
  - addr increments (same wrap rule), rd_strobe pulses, tx reloads.
  - the following fall presents the new MSB.
- MISO is 0 during the whole command byte and during all write frames.
- SS_n rise (any state) -> IDLE within SYNC_STAGES+1 cycles:
  - busy=0, spi_MISO_oe=0, spi_MISO=0.
  - a partial byte (<8 bits) is discarded, with no wr_valid and no rd_strobe.
- SCLK edges with SS_n high: no effect.
- SS_n toggling with no SCLK: empty frame, no strobes.
- Reset asserted mid-frame: immediate return to reset values. After reset release, an SS_n already held low is not treated as a frame start; a falling edge is required.
- Latency: wr_valid appears <= SYNC_STAGES+2 clk_clk cycles after the 8th SCLK rise.

Optional Feature:
- Macro SPI_TARGET_IRQ_EN.
- Defined: adds output port irq, 1 bit, reset 0.
  - irq pulses for one cycle on the SS_n-rise return to IDLE when the frame produced at least one wr_valid.
  - Frames that are read-only, empty or aborted before the first complete data byte produce no pulse.
- Undefined: port irq is absent and the tracking flop is not built. All other behaviour is identical.

Test Plan:
- Write burst: SS_n low; send 0x85, 0x11, 0x22; SS_n high -> wr_valid twice: (addr 0x05, 0x11), then (0x06, 0x22). busy falls after SS_n high.
- Read burst: send 0x10 then two dummy bytes; local model returns rd_data = addr ^ 0xA5 -> MISO bytes 0xB5, 0xB4; rd_addr sequence 0x10, 0x11, 0x12.
- Wrap-around: write command 0xFF, data 0xAA, 0xBB -> wr_addr 0x7F then 0x00.
- Abort: command 0x83, then 5 data bits, SS_n high -> no wr_valid; next frame 0x83, 0x44 -> wr_valid (0x03, 0x44).
- Reset mid-frame: assert reset_reset_n=0 after the 4th data bit of a write -> all outputs 0. Frame restarted after reset writes correctly.
- SPI_TARGET_IRQ_EN build: write frame -> one irq pulse after SS_n rise; read-only frame -> irq stays 0.
